// File: rtl/core_mem_port.sv
// core_mem_port
// Memory-side port for the core. Turns the core's blocking request/done
// accesses into a req/ack handshake toward external memory. Writes are posted
// into a small FIFO so the core is released after one cycle; reads that match
// a posted write are answered from the FIFO, and reads that miss go to memory
// ahead of any queued writes.
//
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-low reset
//   core_req          core access request, held until core_done
//   core_address      access address
//   core_rw           1 = read, 0 = write
//   core_datao        write data from the core
//   core_data         registered read result, holds the last read
//   core_done         one-cycle completion pulse
//   core_stall        core_req & ~core_done
//   mem_req/mem_we    memory request and direction (1 = write)
//   mem_addr          memory address
//   mem_wdata         memory write data
//   mem_ack           memory completion for the current transaction
//   mem_rdata         memory read data, valid with mem_ack
//   wb_count          number of occupied posted-write entries
module core_mem_port #(
    parameter int AW       = 64,
    parameter int DW       = 64,
    parameter int WB_DEPTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      core_req,
    input  logic [AW-1:0]             core_address,
    input  logic                      core_rw,
    input  logic [DW-1:0]             core_datao,
    output logic [DW-1:0]             core_data,
    output logic                      core_done,
    output logic                      core_stall,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic                      mem_ack,
    input  logic [DW-1:0]             mem_rdata,
    output logic [$clog2(WB_DEPTH):0] wb_count
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        M_IDLE,
        M_READ,
        M_WRITE
    } mem_state_t;

    mem_state_t    state;
    logic [AW-1:0] wb_addr [WB_DEPTH];
    logic [DW-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          read_pending;
    logic [AW-1:0] read_addr;

    logic          accept;
    logic          pop;
    logic          push;
    logic          full;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic          read_hit;
    logic          read_miss;
    logic [CW-1:0] remain;
    logic [PW-1:0] next_idx;
    logic          wr_avail;
    logic [AW-1:0] wr_next_addr;
    logic [DW-1:0] wr_next_data;
    logic          rd_go;
    logic [AW-1:0] rd_next_addr;
    logic          xfer_end;
    logic          issue_read;
    logic          issue_write;

    assign core_stall = core_req & ~core_done;

    // A request is only taken when the previous one has finished: the done
    // cycle itself is ignored, and a read miss blocks further requests until
    // memory answers it. A write needs a free slot, or the slot freed by a
    // pop on the same edge.
    always_comb begin
        accept    = core_req & ~core_done & ~read_pending;
        pop       = (state == M_WRITE) & mem_ack;
        full      = (wb_count == CW'(WB_DEPTH));
        push      = accept & ~core_rw & (~full | pop);
        read_hit  = accept & core_rw & hit;
        read_miss = accept & core_rw & ~hit;
    end

    // Scan the FIFO from oldest to newest so the newest matching entry wins
    // when the same address was posted more than once.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((CW'(i) < wb_count) && (wb_addr[head + PW'(i)] == core_address)) begin
                hit      = 1'b1;
                hit_data = wb_data[head + PW'(i)];
            end
        end
    end

    // Work out what the memory side does at the coming edge. The write to
    // issue is the entry after the one being popped; when the FIFO would
    // otherwise be empty, a write being pushed right now is sent directly so
    // it reaches memory one cycle after acceptance. A read miss accepted this
    // cycle is issued directly from the core address for the same reason.
    // The read currently in flight does not count as a new read to issue.
    always_comb begin
        remain       = wb_count - CW'(pop);
        next_idx     = head + PW'(pop);
        wr_avail     = (remain != '0) | push;
        wr_next_addr = (remain != '0) ? wb_addr[next_idx] : core_address;
        wr_next_data = (remain != '0) ? wb_data[next_idx] : core_datao;
        rd_go        = (read_pending & (state != M_READ)) | read_miss;
        rd_next_addr = read_pending ? read_addr : core_address;
        xfer_end     = (state == M_IDLE) | mem_ack;
        issue_read   = xfer_end & rd_go;
        issue_write  = xfer_end & ~rd_go & wr_avail;
    end

    // Posted-write storage. Contents need no reset because wb_count decides
    // which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr[tail] <= core_address;
            wb_data[tail] <= core_datao;
        end
    end

    // FIFO pointers, core-side completion and the memory FSM. Memory outputs
    // are only reloaded when a new transaction starts, so they stay stable
    // for the whole req/ack exchange.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= M_IDLE;
            head         <= '0;
            tail         <= '0;
            wb_count     <= '0;
            read_pending <= 1'b0;
            read_addr    <= '0;
            core_data    <= '0;
            core_done    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            core_done <= 1'b0;
            wb_count  <= wb_count + CW'(push) - CW'(pop);

            if (push) begin
                tail      <= tail + PW'(1);
                core_done <= 1'b1;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (read_hit) begin
                core_data <= hit_data;
                core_done <= 1'b1;
            end
            if (read_miss) begin
                read_pending <= 1'b1;
                read_addr    <= core_address;
            end
            if ((state == M_READ) && mem_ack) begin
                core_data    <= mem_rdata;
                core_done    <= 1'b1;
                read_pending <= 1'b0;
            end

            if (issue_read) begin
                state    <= M_READ;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_next_addr;
            end else if (issue_write) begin
                state     <= M_WRITE;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_next_addr;
                mem_wdata <= wr_next_data;
            end else if (xfer_end) begin
                state   <= M_IDLE;
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port
// Directed bench for core_mem_port. A reference memory tracks what the core
// should see, a scoreboard queue holds the expected result of each access,
// and a responder process plays the memory with programmable ack behaviour.
module tb_core_mem_port;

    localparam int AW       = 64;
    localparam int DW       = 64;
    localparam int WB_DEPTH = 4;

    logic          clock;
    logic          reset;
    logic          core_req;
    logic [63:0]   core_address;
    logic          core_rw;
    logic [63:0]   core_datao;
    logic [63:0]   core_data;
    logic          core_done;
    logic          core_stall;
    logic          mem_req;
    logic          mem_we;
    logic [63:0]   mem_addr;
    logic [63:0]   mem_wdata;
    logic          mem_ack;
    logic [63:0]   mem_rdata;
    logic [2:0]    wb_count;

    core_mem_port #(.AW(AW), .DW(DW), .WB_DEPTH(WB_DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .core_req     (core_req),
        .core_address (core_address),
        .core_rw      (core_rw),
        .core_datao   (core_datao),
        .core_data    (core_data),
        .core_done    (core_done),
        .core_stall   (core_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_count     (wb_count)
    );

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } txn_t;

    typedef struct {
        bit          is_read;
        logic [63:0] data;
    } exp_t;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          ack_lat = 3;
    bit          ack_tied = 0;
    bit          ack_unlimited = 1;
    int          ack_limit = 0;
    int          acks_given = 0;
    int          req_cycles = 0;
    int          log_base = 0;
    txn_t        mem_log[$];
    exp_t        sb[$];
    logic [63:0] mem_model [logic [63:0]];
    logic [63:0] ref_mem [logic [63:0]];

    // Free-running clock and cycle index used to time-stamp memory acks.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: decides the ack at each falling edge so it is stable at
    // the next rising edge, and logs every completed transaction.
    initial begin
        bit a;
        mem_ack          = 1'b0;
        mem_rdata        = '0;
        mem_model[64'h99] = 64'h55;
        forever begin
            @(negedge clock);
            if (mem_req !== 1'b1) begin
                req_cycles = 0;
                mem_ack    = ack_tied;
            end else begin
                req_cycles++;
                a = ack_tied | ((req_cycles >= ack_lat) && (ack_unlimited || (acks_given < ack_limit)));
                mem_ack   = a;
                mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'd0;
                if (a) begin
                    acks_given++;
                    mem_log.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata, cyc});
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    req_cycles = 0;
                end
            end
        end
    end

    // Hard stop in case something never finishes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // n < 0 lets memory ack freely, otherwise only n more acks are granted.
    task automatic set_acks(input int n);
        if (n < 0) begin
            ack_unlimited = 1;
        end else begin
            ack_limit     = acks_given + n;
            ack_unlimited = 0;
        end
    endtask

    task automatic applyStimulus(input bit rw, input logic [63:0] addr, input logic [63:0] data);
        exp_t e;
        e.is_read = rw;
        if (rw) begin
            e.data = ref_mem.exists(addr) ? ref_mem[addr] : 64'd0;
        end else begin
            e.data        = 64'd0;
            ref_mem[addr] = data;
        end
        sb.push_back(e);
        core_req     = 1'b1;
        core_rw      = rw;
        core_address = addr;
        core_datao   = data;
    endtask

    // Waits for core_done (bounded), checks latency when exp_lat > 0 and
    // the read data against the scoreboard. Returns in the done cycle.
    task automatic checkOutput(input string tag, input int exp_lat);
        int   n;
        exp_t e;
        n = 0;
        while (core_done !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check_eq({tag, "_done"}, 64'(core_done), 64'd1);
        if (exp_lat > 0) check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_read) check_eq({tag, "_data"}, core_data, e.data);
        end
        core_req = 1'b0;
    endtask

    task automatic do_access(input bit rw, input logic [63:0] addr, input logic [63:0] data,
                             input string tag, input int exp_lat);
        applyStimulus(rw, addr, data);
        checkOutput(tag, exp_lat);
        step(1);
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (wb_count !== 3'd0 && n < 100) begin
            step(1);
            n++;
        end
        check_eq(tag, 64'(wb_count), 64'd0);
    endtask

    initial begin
        int seen;
        reset        = 1'b0;
        core_req     = 1'b0;
        core_rw      = 1'b0;
        core_address = '0;
        core_datao   = '0;

        // Reset values
        step(3);
        check_eq("rst_core_data", core_data, 64'd0);
        check_eq("rst_core_done", 64'(core_done), 64'd0);
        check_eq("rst_mem_req", 64'(mem_req), 64'd0);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_mem_wdata", mem_wdata, 64'd0);
        check_eq("rst_wb_count", 64'(wb_count), 64'd0);
        reset = 1'b1;
        step(2);

        // Post and drain with ack latency 3
        $display("[TB] post and drain");
        log_base = mem_log.size();
        applyStimulus(1'b0, 64'h10, 64'hAA);
        checkOutput("post", 1);
        check_eq("post_mem_req", 64'(mem_req), 64'd1);
        check_eq("post_mem_we", 64'(mem_we), 64'd1);
        check_eq("post_mem_addr", mem_addr, 64'h10);
        check_eq("post_mem_wdata", mem_wdata, 64'hAA);
        check_eq("post_wb_count", 64'(wb_count), 64'd1);
        step(2);
        check_eq("post_wb_before_ack", 64'(wb_count), 64'd1);
        step(1);
        check_eq("post_wb_after_ack", 64'(wb_count), 64'd0);
        check_eq("post_mem_req_idle", 64'(mem_req), 64'd0);
        check_eq("post_log_size", 64'(mem_log.size() - log_base), 64'd1);
        ack_lat = 1;

        // Forward the newest posted write
        $display("[TB] forwarding");
        set_acks(0);
        log_base = mem_log.size();
        do_access(1'b0, 64'h20, 64'h1, "fwd_w1", 1);
        do_access(1'b0, 64'h20, 64'h2, "fwd_w2", 1);
        check_eq("fwd_wb_count", 64'(wb_count), 64'd2);
        do_access(1'b1, 64'h20, 64'h0, "fwd_r", 1);
        check_eq("fwd_no_mem", 64'(mem_log.size() - log_base), 64'd0);
        check_eq("fwd_mem_we", 64'(mem_we), 64'd1);
        set_acks(-1);
        wait_empty("fwd_drain");
        check_eq("fwd_log_size", 64'(mem_log.size() - log_base), 64'd2);
        if (mem_log.size() - log_base == 2) begin
            check_eq("fwd_log0_data", mem_log[log_base].data, 64'h1);
            check_eq("fwd_log1_data", mem_log[log_base + 1].data, 64'h2);
        end

        // Read miss bypasses queued writes
        $display("[TB] miss priority");
        ref_mem[64'h99] = 64'h55;
        set_acks(0);
        log_base = mem_log.size();
        do_access(1'b0, 64'h30, 64'h300, "prio_w0", 1);
        do_access(1'b0, 64'h31, 64'h310, "prio_w1", 1);
        do_access(1'b0, 64'h32, 64'h320, "prio_w2", 1);
        check_eq("prio_wb_count", 64'(wb_count), 64'd3);
        set_acks(2);
        applyStimulus(1'b1, 64'h99, 64'h0);
        checkOutput("prio_r", 0);
        check_eq("prio_log_size", 64'(mem_log.size() - log_base), 64'd2);
        if (mem_log.size() - log_base == 2) begin
            check_eq("prio_first_addr", mem_log[log_base].addr, 64'h30);
            check_eq("prio_read_we", 64'(mem_log[log_base + 1].we), 64'd0);
            check_eq("prio_read_addr", mem_log[log_base + 1].addr, 64'h99);
            check_eq("prio_done_cycle", 64'(cyc), 64'(mem_log[log_base + 1].cyc + 1));
        end
        check_eq("prio_wb_count_after", 64'(wb_count), 64'd2);
        check_eq("prio_next_addr", mem_addr, 64'h31);
        check_eq("prio_next_we", 64'(mem_we), 64'd1);
        step(1);
        set_acks(-1);
        wait_empty("prio_drain");
        check_eq("prio_total", 64'(mem_log.size() - log_base), 64'd4);
        if (mem_log.size() - log_base == 4) begin
            check_eq("prio_order2", mem_log[log_base + 2].addr, 64'h31);
            check_eq("prio_order3", mem_log[log_base + 3].addr, 64'h32);
        end

        // Full FIFO: fifth write waits for a pop
        $display("[TB] full fifo");
        set_acks(0);
        log_base = mem_log.size();
        for (int i = 0; i < WB_DEPTH; i++) begin
            do_access(1'b0, 64'h40 + 64'(i), 64'h400 + 64'(i), "full_w", 1);
        end
        check_eq("full_wb_count", 64'(wb_count), 64'd4);
        applyStimulus(1'b0, 64'h44, 64'h444);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("full_stall", 64'(core_stall), 64'd1);
            check_eq("full_held", 64'(wb_count), 64'd4);
        end
        set_acks(1);
        checkOutput("full_w5", 0);
        check_eq("full_wb_at_done", 64'(wb_count), 64'd4);
        if (mem_log.size() - log_base == 1) begin
            check_eq("full_done_cycle", 64'(cyc), 64'(mem_log[log_base].cyc + 1));
        end
        step(1);
        set_acks(-1);
        wait_empty("full_drain");
        check_eq("full_total", 64'(mem_log.size() - log_base), 64'd5);
        if (mem_log.size() - log_base == 5) begin
            check_eq("full_last_addr", mem_log[log_base + 4].addr, 64'h44);
            check_eq("full_last_data", mem_log[log_base + 4].data, 64'h444);
        end

        // Zero-wait memory
        $display("[TB] zero wait");
        ack_tied = 1;
        do_access(1'b0, 64'h50, 64'h5, "zw_w0", 1);
        do_access(1'b1, 64'h50, 64'h0, "zw_r0", 2);
        do_access(1'b0, 64'h51, 64'h6, "zw_w1", 1);
        do_access(1'b1, 64'h51, 64'h0, "zw_r1", 2);
        do_access(1'b1, 64'h10, 64'h0, "zw_r2", 2);

        // Back-to-back drain once memory starts acking every cycle
        ack_tied = 0;
        set_acks(0);
        do_access(1'b0, 64'h60, 64'h600, "b2b_w0", 1);
        do_access(1'b0, 64'h61, 64'h610, "b2b_w1", 1);
        do_access(1'b0, 64'h62, 64'h620, "b2b_w2", 1);
        ack_tied = 1;
        for (int i = 0; i < 3; i++) begin
            check_eq("b2b_req", 64'(mem_req), 64'd1);
            check_eq("b2b_addr", mem_addr, 64'h60 + 64'(i));
            step(1);
        end
        check_eq("b2b_req_end", 64'(mem_req), 64'd0);
        check_eq("b2b_wb_count", 64'(wb_count), 64'd0);

        // Reset while a read is outstanding with writes queued
        $display("[TB] reset mid-operation");
        ack_tied = 0;
        set_acks(0);
        do_access(1'b0, 64'h70, 64'h700, "rst_w0", 1);
        do_access(1'b0, 64'h71, 64'h710, "rst_w1", 1);
        do_access(1'b0, 64'h72, 64'h720, "rst_w2", 1);
        set_acks(1);
        applyStimulus(1'b1, 64'h98, 64'h0);
        step(2);
        check_eq("mid_mem_we", 64'(mem_we), 64'd0);
        check_eq("mid_mem_addr", mem_addr, 64'h98);
        check_eq("mid_wb_count", 64'(wb_count), 64'd2);
        reset = 1'b0;
        #1;
        check_eq("async_mem_req", 64'(mem_req), 64'd0);
        check_eq("async_core_done", 64'(core_done), 64'd0);
        check_eq("async_wb_count", 64'(wb_count), 64'd0);
        core_req = 1'b0;
        sb.delete();
        ref_mem  = mem_model;
        ack_tied = 1;
        step(2);
        reset = 1'b1;
        seen  = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (mem_req === 1'b1 || core_done === 1'b1) seen++;
        end
        check_eq("post_reset_quiet", 64'(seen), 64'd0);
        do_access(1'b1, 64'h70, 64'h0, "after_rst_r0", 2);
        do_access(1'b1, 64'h71, 64'h0, "after_rst_r1", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
